// File: rtl/alu4_serial_ctrl.sv
// +--------------------------------------------------------------------------+
// | alu4_serial_ctrl: nibble-serial sequencer over one shared 4-bit ALU slice |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu4_serial_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             op,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   zero,
  output logic                   overflow,
  output logic                   carry,
  output logic                   size
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, result_q, result_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cin_q, cin_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, carry_q, carry_d, size_q, size_d;

  logic             is_arith, inv_b;
  logic [3:0]       a_nib, b_nib, nib_res;
  logic [4:0]       sum5;
  logic             nib_cout, nib_ovf;

  // Add, sub, signed-less-than and equality all go through the adder; the last three subtract.
  always_comb begin
    is_arith = (op_q[2:1] == 2'b00) || (op_q[2:1] == 2'b11);
    inv_b    = (op_q == 3'b001) || (op_q[2:1] == 2'b11);
    a_nib    = a_q[4*idx_q +: 4];
    b_nib    = inv_b ? ~b_q[4*idx_q +: 4] : b_q[4*idx_q +: 4];
    sum5     = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, cin_q};
    nib_res  = sum5[3:0];
    nib_cout = 1'b0;
    case (op_q)
      3'b010:  nib_res = ~a_nib;
      3'b011:  nib_res = a_nib & b_nib;
      3'b100:  nib_res = a_nib | b_nib;
      3'b101:  nib_res = a_nib ^ b_nib;
      default: nib_cout = sum5[4];
    endcase
    nib_ovf = is_arith && (a_nib[3] == b_nib[3]) && (nib_res[3] != a_nib[3]);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    cin_d    = cin_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    carry_d  = carry_q;
    size_d   = size_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          cin_d   = (op == 3'b001) || (op[2:1] == 2'b11);
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[4*idx_q +: 4] = nib_res;
        cin_d                  = nib_cout;
        if (idx_q == LAST_IDX) begin
          zero_d  = (result_d == '0);
          ovf_d   = nib_ovf;
          carry_d = nib_cout;
          size_d  = (op_q == 3'b110) ? (nib_res[3] ^ nib_ovf) :
                    (op_q == 3'b111) ? (result_d == '0) : 1'b0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      cin_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      carry_q  <= 1'b0;
      size_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      cin_q    <= cin_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      carry_q  <= carry_d;
      size_q   <= size_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign carry     = carry_q;
  assign size      = size_q;

endmodule

`default_nettype wire

// File: tb/tb_alu4_serial_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_alu4_serial_ctrl: directed self-checking bench, NIBBLES = 4           |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu4_serial_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'b000;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        zero, overflow, carry, size;

  int vectors = 0;
  int miscompares = 0;

  alu4_serial_ctrl #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .carry     (carry),
    .size      (size)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op and wait (bounded) for out_valid, checking the accept-to-valid latency.
  task automatic issue(input string tag, input logic [2:0] o, input logic [15:0] av, input logic [15:0] bv);
    int lat;
    @(negedge clk);
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    op = o;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".latency"}, lat, 32'd4);
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [15:0] r, input logic z,
                            input logic ov, input logic c, input logic s);
    check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".result"},    {16'd0, result},    {16'd0, r});
    check({tag, ".zero"},      {31'd0, zero},      {31'd0, z});
    check({tag, ".overflow"},  {31'd0, overflow},  {31'd0, ov});
    check({tag, ".carry"},     {31'd0, carry},     {31'd0, c});
    check({tag, ".size"},      {31'd0, size},      {31'd0, s});
  endtask

  task automatic retire(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".retire_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".retire_ready"}, {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    logic [15:0] held;

    // Reset state
    #2;
    check("rst.in_ready",  {31'd0, in_ready},  32'd1);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.result",    {16'd0, result},    32'd0);
    check("rst.flags",     {28'd0, zero, overflow, carry, size}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue("add_ovf", 3'b000, 16'h7FFF, 16'h0001);
    expect_out("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
    retire("add_ovf");

    issue("sub_eq", 3'b001, 16'h0005, 16'h0005);
    expect_out("sub_eq", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    retire("sub_eq");

    issue("sub_neg", 3'b001, 16'h0003, 16'h0005);
    expect_out("sub_neg", 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    retire("sub_neg");

    issue("slt_m1_1", 3'b110, 16'hFFFF, 16'h0001);
    expect_out("slt_m1_1", 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b1);
    retire("slt_m1_1");

    issue("slt_min_max", 3'b110, 16'h8000, 16'h7FFF);
    expect_out("slt_min_max", 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1);
    retire("slt_min_max");

    issue("slt_1_m1", 3'b110, 16'h0001, 16'hFFFF);
    expect_out("slt_1_m1", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    retire("slt_1_m1");

    issue("eq_same", 3'b111, 16'h1234, 16'h1234);
    expect_out("eq_same", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
    retire("eq_same");

    issue("eq_diff", 3'b111, 16'h1234, 16'h1235);
    expect_out("eq_diff", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    retire("eq_diff");

    issue("and", 3'b011, 16'hF0F0, 16'hFF00);
    expect_out("and", 16'hF000, 1'b0, 1'b0, 1'b0, 1'b0);
    retire("and");

    issue("not", 3'b010, 16'h0F0F, 16'h1234);
    expect_out("not", 16'hF0F0, 1'b0, 1'b0, 1'b0, 1'b0);
    retire("not");

    issue("or", 3'b100, 16'h00F0, 16'h0F00);
    expect_out("or", 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
    retire("or");

    issue("xor_zero", 3'b101, 16'hA5A5, 16'hA5A5);
    expect_out("xor_zero", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    retire("xor_zero");

    // Backpressure: DONE held with out_ready low and in_valid asserted
    issue("bp", 3'b000, 16'h1111, 16'h2222);
    held = result;
    check("bp.result", {16'd0, held}, 32'h3333);
    in_valid = 1'b1;
    op = 3'b000;
    a = 16'hFFFF;
    b = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp.hold_ready", {31'd0, in_ready},  32'd0);
      check("bp.hold_result", {16'd0, result},   {16'd0, held});
    end
    in_valid = 1'b0;
    retire("bp");
    check("bp.result_kept", {16'd0, result}, 32'h3333);

    // Reset while RUN is at idx=2
    @(negedge clk);
    in_valid = 1'b1;
    op = 3'b000;
    a = 16'h7777;
    b = 16'h1111;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst.out_valid", {31'd0, out_valid}, 32'd0);
    check("arst.in_ready",  {31'd0, in_ready},  32'd1);
    check("arst.result",    {16'd0, result},    32'd0);
    check("arst.flags",     {28'd0, zero, overflow, carry, size}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    issue("post_rst", 3'b000, 16'h1234, 16'h1111);
    expect_out("post_rst", 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0);
    retire("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
